pe_param: RTL and testbench
===========================

PE_PARAM -- requirements
Module: pe_param

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits (power of two, >=4).
REQ-002 Parameter NUM_NBR, default 4, number of neighbour-PE input channels.
REQ-003 Parameter RF_DEPTH, default 4, entries in the local register file (power of two, >=2).
REQ-004 Derived: NSRC=NUM_NBR+RF_DEPTH+2; SELW=clog2(NSRC); AW=clog2(RF_DEPTH); SHW=clog2(WIDTH); CFG_W=4+2*SELW+AW+2 (16 at defaults).
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  pipeline advance enable; 0 = stall.
REQ-008 cfg_we  input  1  load cfg_in into the configuration register.
REQ-009 cfg_in  input  CFG_W  configuration word.
REQ-010 nbr_in  input  NUM_NBR*WIDTH  neighbour outputs, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 ext_in0, ext_in1  input  WIDTH each  external operands for operand 0 / operand 1.
REQ-012 in_valid  input  1  current operands constitute a valid issue.
REQ-013 out  output  WIDTH  registered ALU result.
REQ-014 out_valid  output  1  out holds the result of a valid issue.

Function
REQ-015 Config fields, LSB first: op[3:0], sel0[SELW], sel1[SELW], wb_en, wb_addr[AW], acc_en.
REQ-016 cfg_we=1 loads cfg_in at the edge regardless of en; the new word governs the next operand capture.
REQ-017 Source index per operand: 0..NUM_NBR-1 neighbour channel; NUM_NBR..NUM_NBR+RF_DEPTH-1 RF entry; NUM_NBR+RF_DEPTH own ext_in (ext_in0 for sel0, ext_in1 for sel1); NUM_NBR+RF_DEPTH+1 accumulator; any higher index selects 0.
REQ-018 Stage 1 (en=1): capture selected operands, in_valid, op, wb_en, wb_addr, acc_en into stage-1 registers.
REQ-019 Stage 2 (en=1): out <= ALU(stage-1 operands, stage-1 op); out_valid <= stage-1 valid.
REQ-020 Latency: 2 enabled edges from issue to out; throughput one issue per enabled cycle.
REQ-021 ALU ops, results mod 2^WIDTH, unsigned: 0 OR, 1 AND, 2 XOR, 3 a<<b[SHW-1:0], 4 a+b, 5 a-b, 6 a>>b[SHW-1:0] logical, 7 pass a, 8 min, 9 max, 10-15 zero.
REQ-022 At stage-2 edge with stage-1 valid=1: wb_en=1 writes result to RF[wb_addr]; acc_en=1 writes result to accumulator.
REQ-023 Stage-1 valid=0: out still updates, but RF, accumulator unchanged.
REQ-024 No bypass: a stage-1 read of an RF entry or accumulator written at the same edge gets the old value; dependent issues must be spaced by one cycle.
REQ-025 en=0: stage-1/stage-2 registers, RF, accumulator, out, out_valid all hold; only config register may change (REQ-016).
REQ-026 Config fields used in stage 2 are the pipelined copies from capture time, never the live config register.

Reset
REQ-027 reset_n=0 immediately clears config register, all stage registers, RF entries, accumulator, out=0, out_valid=0, independent of clock and en.
REQ-028 Reset asserted mid-operation discards in-flight issues; first valid out after release requires a fresh issue plus 2 enabled edges.

Verification (WIDTH=8, NUM_NBR=4, RF_DEPTH=4; ext=8, acc=9)
REQ-029 Pulse reset_n low mid-stream with out_valid=1 -> out=0x00, out_valid=0 asynchronously, RF and accumulator read back 0.
REQ-030 op=4, sel0=8, sel1=0, ext_in0=0xF0, nbr ch0=0x20, single valid issue -> out=0x10, out_valid=1 exactly 2 edges later, then out_valid=0.
REQ-031 op=3, sel0=8, sel1=8, ext_in0=0x81, ext_in1=0x0B -> out=0x08 (shift 3); op=6 same operands -> 0x10; op=12 -> 0x00.
REQ-032 op=4, sel0=9, sel1=8, acc_en=1, ext_in1=0x03, four valid issues on alternate cycles -> out sequence 0x03,0x06,0x09,0x0C; back-to-back issues -> second result 0x03 (no bypass).
REQ-033 op=7, sel0=8, ext_in0=0x5A, wb_en=1, wb_addr=2; next-but-one issue op=7, sel0=6 -> out=0x5A; sel0=14 -> out=0x00.
REQ-034 Drop en for 3 cycles with two issues in flight while toggling cfg_we -> out/out_valid frozen; after en returns results appear in order using capture-time op.

Source files
------------

// File: rtl/pe_param.sv
// Parameterised processing element: two-stage operand-select / ALU pipeline with a
// local register file, accumulator and a run-time configuration word.
module pe_param #(
  parameter  int WIDTH    = 8,
  parameter  int NUM_NBR  = 4,
  parameter  int RF_DEPTH = 4,
  localparam int NSRC     = NUM_NBR + RF_DEPTH + 2,
  localparam int SELW     = $clog2(NSRC),
  localparam int AW       = $clog2(RF_DEPTH),
  localparam int SHW      = $clog2(WIDTH),
  localparam int CFG_W    = 4 + 2*SELW + AW + 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     cfg_we,
  input  logic [CFG_W-1:0]         cfg_in,
  input  logic [NUM_NBR*WIDTH-1:0] nbr_in,
  input  logic [WIDTH-1:0]         ext_in0,
  input  logic [WIDTH-1:0]         ext_in1,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid
);

  localparam int SRC_EXT = NUM_NBR + RF_DEPTH;
  localparam int SRC_ACC = NUM_NBR + RF_DEPTH + 1;

  logic [CFG_W-1:0] r_cfg;
  logic [3:0]       w_op;
  logic [SELW-1:0]  w_sel [2];
  logic             w_wb_en;
  logic [AW-1:0]    w_wb_addr;
  logic             w_acc_en;

  assign w_op      = r_cfg[3:0];
  assign w_sel[0]  = r_cfg[4 +: SELW];
  assign w_sel[1]  = r_cfg[4+SELW +: SELW];
  assign w_wb_en   = r_cfg[4+2*SELW];
  assign w_wb_addr = r_cfg[5+2*SELW +: AW];
  assign w_acc_en  = r_cfg[5+2*SELW+AW];

  logic [WIDTH-1:0] w_nbr  [NUM_NBR];
  logic [WIDTH-1:0] w_ext  [2];
  logic [WIDTH-1:0] w_opnd [2];
  logic [WIDTH-1:0] r_rf   [RF_DEPTH];
  logic [WIDTH-1:0] r_acc;

  for (genvar g = 0; g < NUM_NBR; g++) begin : g_nbr
    assign w_nbr[g] = nbr_in[g*WIDTH +: WIDTH];
  end

  assign w_ext[0] = ext_in0;
  assign w_ext[1] = ext_in1;

  // Unassigned source indices fall through to zero.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_opnd[k] = '0;
      for (int i = 0; i < NUM_NBR; i++)
        if (w_sel[k] == SELW'(i)) w_opnd[k] = w_nbr[i];
      for (int i = 0; i < RF_DEPTH; i++)
        if (w_sel[k] == SELW'(NUM_NBR + i)) w_opnd[k] = r_rf[i];
      if (w_sel[k] == SELW'(SRC_EXT)) w_opnd[k] = w_ext[k];
      if (w_sel[k] == SELW'(SRC_ACC)) w_opnd[k] = r_acc;
    end
  end

  // Stage-1 registers carry the capture-time config so later cfg writes cannot leak in.
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_op;
  logic             r_wb_en, r_acc_en;
  logic [AW-1:0]    r_wb_addr;
  logic [2:1]       r_vld_pipe;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_alu;

  always_comb begin
    w_alu = '0;
    case (r_op)
      4'd0:    w_alu = r_a | r_b;
      4'd1:    w_alu = r_a & r_b;
      4'd2:    w_alu = r_a ^ r_b;
      4'd3:    w_alu = r_a << r_b[SHW-1:0];
      4'd4:    w_alu = r_a + r_b;
      4'd5:    w_alu = r_a - r_b;
      4'd6:    w_alu = r_a >> r_b[SHW-1:0];
      4'd7:    w_alu = r_a;
      4'd8:    w_alu = (r_a < r_b) ? r_a : r_b;
      4'd9:    w_alu = (r_a < r_b) ? r_b : r_a;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_cfg <= '0;
    else if (cfg_we) r_cfg <= cfg_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_acc_en   <= 1'b0;
      r_vld_pipe <= '0;
      r_out      <= '0;
      r_acc      <= '0;
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else if (en) begin
      r_a           <= w_opnd[0];
      r_b           <= w_opnd[1];
      r_op          <= w_op;
      r_wb_en       <= w_wb_en;
      r_wb_addr     <= w_wb_addr;
      r_acc_en      <= w_acc_en;
      r_vld_pipe[1] <= in_valid;
      r_vld_pipe[2] <= r_vld_pipe[1];
      r_out         <= w_alu;
      // No bypass: a capture at this same edge already sampled the old RF/acc.
      if (r_vld_pipe[1]) begin
        if (r_wb_en)  r_rf[r_wb_addr] <= w_alu;
        if (r_acc_en) r_acc           <= w_alu;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld_pipe[2];

endmodule

// File: tb/tb_pe_param.sv
// Bench for pe_param at default parameters: directed vector table, multi-cycle corner
// sequences and a random stream, all compared against an issue-level reference model.
module tb_pe_param;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en, cfg_we, in_valid;
  logic [15:0] cfg_in;
  logic [31:0] nbr_in;
  logic [7:0]  ext_in0, ext_in1;
  logic [7:0]  out;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  pe_param dut (
    .clock(clock), .reset_n(reset_n), .en(en), .cfg_we(cfg_we), .cfg_in(cfg_in),
    .nbr_in(nbr_in), .ext_in0(ext_in0), .ext_in1(ext_in1), .in_valid(in_valid),
    .out(out), .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  // Reference model: one outstanding issue record awaiting its ALU result.
  typedef struct {
    logic       v;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       wb;
    logic [1:0] addr;
    logic       acc;
  } iss_t;

  logic [15:0] m_cfg;
  logic [7:0]  m_rf [4];
  logic [7:0]  m_acc, m_out;
  logic        m_ov;
  iss_t        pend;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int s0, input int s1,
                                     input int wb, input int addr, input int acc);
    logic [15:0] c;
    c = 16'(op % 16) | 16'((s0 % 16) << 4) | 16'((s1 % 16) << 8)
      | 16'((wb % 2) << 12) | 16'((addr % 4) << 13) | 16'((acc % 2) << 15);
    return c;
  endfunction

  function automatic logic [7:0] m_src(input int sel, input logic [7:0] ext);
    if (sel < 4)       return nbr_in[sel*8 +: 8];
    else if (sel < 8)  return m_rf[sel-4];
    else if (sel == 8) return ext;
    else if (sel == 9) return m_acc;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_alu(input int op, input int a, input int b);
    case (op)
      0: return 8'(a | b);
      1: return 8'(a & b);
      2: return 8'(a ^ b);
      3: return 8'((a << (b % 8)) % 256);
      4: return 8'((a + b) % 256);
      5: return 8'((a - b + 256) % 256);
      6: return 8'(a >> (b % 8));
      7: return 8'(a);
      8: return 8'((a < b) ? a : b);
      9: return 8'((a < b) ? b : a);
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_cfg = '0; m_acc = '0; m_out = '0; m_ov = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    pend = '{v: 1'b0, op: 4'd0, a: 8'd0, b: 8'd0, wb: 1'b0, addr: 2'd0, acc: 1'b0};
  endtask

  // One clock edge: the model captures with pre-edge state, then retires the older issue.
  task automatic tick();
    iss_t       nw;
    logic [7:0] r;
    nw = pend;
    if (en) begin
      nw.v    = in_valid;
      nw.op   = m_cfg[3:0];
      nw.a    = m_src(int'(m_cfg[7:4]), ext_in0);
      nw.b    = m_src(int'(m_cfg[11:8]), ext_in1);
      nw.wb   = m_cfg[12];
      nw.addr = m_cfg[14:13];
      nw.acc  = m_cfg[15];
    end
    @(posedge clock); #1;
    if (en) begin
      r     = m_alu(int'(pend.op), int'(pend.a), int'(pend.b));
      m_out = r;
      m_ov  = pend.v;
      if (pend.v && pend.wb)  m_rf[pend.addr] = r;
      if (pend.v && pend.acc) m_acc = r;
      pend = nw;
    end
    if (cfg_we) m_cfg = cfg_in;
    chk("model_out", out, m_out);
    chk("model_out_valid", {7'd0, out_valid}, {7'd0, m_ov});
  endtask

  // Load config, issue once, and check the 2-edge latency window.
  task automatic run_vec(input string nm, input logic [15:0] cfg, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] n0, input logic [7:0] exp);
    en = 1'b1; cfg_we = 1'b1; cfg_in = cfg; in_valid = 1'b0;
    tick();
    cfg_we = 1'b0; in_valid = 1'b1; ext_in0 = e0; ext_in1 = e1; nbr_in[7:0] = n0;
    tick();
    chk({nm, "_early_valid"}, {7'd0, out_valid}, 8'd0);
    in_valid = 1'b0;
    tick();
    chk(nm, out, exp);
    chk({nm, "_valid"}, {7'd0, out_valid}, 8'd1);
    tick();
    chk({nm, "_valid_drop"}, {7'd0, out_valid}, 8'd0);
  endtask

  typedef struct {
    string      nm;
    logic [15:0] cfg;
    logic [7:0] e0, e1, n0, exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{"add_nbr_wrap", mk(4, 8, 0, 0, 0, 0), 8'hF0, 8'h00, 8'h20, 8'h10};
    tbl[1]  = '{"shl",          mk(3, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h08};
    tbl[2]  = '{"shr",          mk(6, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h10};
    tbl[3]  = '{"op12_zero",    mk(12, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h00};
    tbl[4]  = '{"or",           mk(0, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h8B};
    tbl[5]  = '{"and",          mk(1, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h01};
    tbl[6]  = '{"xor",          mk(2, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h8A};
    tbl[7]  = '{"sub",          mk(5, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h76};
    tbl[8]  = '{"pass",         mk(7, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h81};
    tbl[9]  = '{"min",          mk(8, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h0B};
    tbl[10] = '{"max",          mk(9, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h81};
    tbl[11] = '{"op15_zero",    mk(15, 8, 8, 0, 0, 0), 8'h81, 8'h0B, 8'h00, 8'h00};
    tbl[12] = '{"sub_wrap",     mk(5, 8, 8, 0, 0, 0), 8'h03, 8'h05, 8'h00, 8'hFE};
    tbl[13] = '{"shl_by7",      mk(3, 8, 8, 0, 0, 0), 8'h01, 8'hFF, 8'h00, 8'h80};
    tbl[14] = '{"sel_hi_zero",  mk(4, 8, 13, 0, 0, 0), 8'h77, 8'h55, 8'h00, 8'h77};
    tbl[15] = '{"and_nbr_ext1", mk(1, 0, 8, 0, 0, 0), 8'h00, 8'hF0, 8'h3C, 8'h30};

    reset_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_in = '0; in_valid = 1'b0;
    nbr_in = '0; ext_in0 = '0; ext_in1 = '0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", out, 8'h00);
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clock); reset_n = 1'b1;

    // Accumulate on alternate cycles, then back-to-back without bypass.
    en = 1'b1; cfg_we = 1'b1; cfg_in = mk(4, 9, 8, 0, 0, 1); in_valid = 1'b0; ext_in1 = 8'h03;
    tick();
    cfg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; tick();
      in_valid = 1'b0; tick();
      chk("acc_seq", out, 8'(3 * (k + 1)));
    end
    in_valid = 1'b1; tick();
    tick();
    in_valid = 1'b0;
    chk("acc_b2b_first", out, 8'h0F);
    tick();
    chk("acc_b2b_second_no_bypass", out, 8'h0F);

    foreach (tbl[i]) run_vec(tbl[i].nm, tbl[i].cfg, tbl[i].e0, tbl[i].e1, tbl[i].n0, tbl[i].exp);

    // RF write-back then read on a later issue.
    run_vec("rf_write", mk(7, 8, 0, 1, 2, 0), 8'h5A, 8'h00, 8'h00, 8'h5A);
    run_vec("rf_read2", mk(7, 6, 0, 0, 0, 0), 8'h00, 8'h00, 8'h00, 8'h5A);
    run_vec("sel14_zero", mk(7, 14, 0, 0, 0, 0), 8'hFF, 8'hFF, 8'hFF, 8'h00);

    // Stall with one issue in stage 1 and one result on out while config toggles.
    en = 1'b1; cfg_we = 1'b1; cfg_in = mk(4, 8, 8, 0, 0, 0); in_valid = 1'b0;
    tick();
    cfg_in = mk(5, 8, 8, 0, 0, 0); in_valid = 1'b1; ext_in0 = 8'h10; ext_in1 = 8'h05;
    tick();
    cfg_we = 1'b0; ext_in0 = 8'h20; ext_in1 = 8'h03;
    tick();
    chk("stall_pre", out, 8'h15);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_we = 1'b1; cfg_in = (k % 2 == 0) ? mk(2, 8, 8, 1, 1, 1) : mk(0, 9, 9, 0, 0, 0);
      ext_in0 = 8'($urandom); ext_in1 = 8'($urandom);
      tick();
      chk("stall_out_hold", out, 8'h15);
      chk("stall_valid_hold", {7'd0, out_valid}, 8'd1);
    end
    en = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    chk("stall_resume_captured_op", out, 8'h1D);
    chk("stall_resume_valid", {7'd0, out_valid}, 8'd1);
    tick();

    // Asynchronous reset while a valid result is on out.
    cfg_we = 1'b1; cfg_in = mk(4, 8, 8, 1, 3, 1); in_valid = 1'b1; ext_in0 = 8'h11; ext_in1 = 8'h22;
    tick();
    cfg_we = 1'b0;
    tick(); tick();
    chk("pre_reset_valid", {7'd0, out_valid}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out", out, 8'h00);
    chk("async_reset_valid", {7'd0, out_valid}, 8'd0);
    m_reset();
    @(negedge clock); reset_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_reset_no_valid", {7'd0, out_valid}, 8'd0);
    for (int s = 4; s < 10; s++)
      if (s != 8) run_vec("post_reset_state_zero", mk(7, s, 0, 0, 0, 0), 8'hAA, 8'hAA, 8'hAA, 8'h00);

    // Random stream against the model.
    for (int n = 0; n < 600; n++) begin
      en       = ($urandom_range(0, 9) < 8);
      cfg_we   = $urandom_range(0, 1) == 1;
      cfg_in   = 16'($urandom);
      in_valid = $urandom_range(0, 1) == 1;
      nbr_in   = $urandom;
      ext_in0  = 8'($urandom);
      ext_in1  = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
